// File: rtl/wb_mem_responder.sv
// Wishbone B4 classic-cycle memory responder with programmable wait states.
// Serves a word-aligned address window from an internal RAM and error-terminates misses.
module wb_mem_responder #(
  parameter int unsigned DEPTH         = 4096,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int unsigned LATENCY       = 1,
  parameter string       MEM_INIT_FILE = ""
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [3:0] LoadCnt = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StTerm} state_e;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic            we_q;
  logic [3:0]      sel_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     dat_q;
  logic            hit_q;
  logic            ack_q;
  logic            err_q;
  logic [31:0]     rdata_q;

  logic [31:0]     mem [DEPTH];

  logic            req;
  logic [31:0]     byte_off;
  logic            hit;
  logic            mem_we;
  logic            unused_off;

  assign req        = cyc_i & stb_i;
  assign byte_off   = addr_i - BASE_ADDR;
  assign hit        = byte_off[31:2] < 30'(DEPTH);
  assign unused_off = ^byte_off[1:0];

  // The access happens on the edge leaving StTerm, the same edge that raises the termination.
  assign mem_we = (state_q == StTerm) & we_q & hit_q;

  always_ff @(posedge sys_clk) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (sel_q[k]) mem[idx_q][8*k +: 8] <= dat_q[8*k +: 8];
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      sel_q   <= 4'd0;
      idx_q   <= '0;
      dat_q   <= 32'h0;
      hit_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req) begin
            we_q  <= we_i;
            sel_q <= sel_i;
            idx_q <= byte_off[AW+1:2];
            dat_q <= data_i;
            hit_q <= hit;
            if (LATENCY == 0) begin
              state_q <= StTerm;
            end else begin
              state_q <= StWait;
              cnt_q   <= LoadCnt;
            end
          end
        end
        StWait: begin
          if (!req) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
          end else if (cnt_q == 4'd0) begin
            state_q <= StTerm;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StTerm: begin
          state_q <= StIdle;
          ack_q   <= hit_q;
          err_q   <= ~hit_q;
          if (hit_q && !we_q) rdata_q <= mem[idx_q];
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ack_o  = ack_q;
  assign err_o  = err_q;
  assign data_o = rdata_q;

endmodule
